// File: rtl/psram_line_fetch_if.sv
// Arbiter-side bus of one PSRAM requester channel.
// The fetch controller is master; the arbiter port is slave.
interface psram_line_fetch_if;
    logic        cmd;
    logic        cmd_en;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        cmd_ready;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output cmd,
        output cmd_en,
        output addr,
        output wdata,
        output mask,
        input  cmd_ready,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  cmd,
        input  cmd_en,
        input  addr,
        input  wdata,
        input  mask,
        output cmd_ready,
        output rdata,
        output rvalid
    );
endinterface

// File: rtl/psram_line_fetch.sv
// Burst read fetcher: PSRAM arbiter channel to line-buffer write port.
// One burst outstanding; abort drains, timeout sets sticky err.
module psram_line_fetch #(
    parameter int BURST_WORDS = 8,
    parameter int LEN_W       = 11,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             psramclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [22:0]      base_addr,
    input  logic [LEN_W-1:0] len_words,
    psram_line_fetch_if.master bus,
    output logic             lb_we,
    output logic [LEN_W-1:0] lb_waddr,
    output logic [31:0]      lb_wdata,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int BCW = $clog2(BURST_WORDS) + 1;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        CHECK
    } state_t;

    state_t           state;
    logic             cmd_en_q;
    logic [22:0]      addr_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_cnt;
    logic [BCW-1:0]   beat_cnt;
    logic [TW-1:0]    to_cnt;
    logic             abort_q;

    assign bus.cmd    = 1'b0;
    assign bus.wdata  = 32'h0;
    assign bus.mask   = 4'hF;
    assign bus.cmd_en = cmd_en_q;
    assign bus.addr   = addr_q;

    always_ff @(posedge psramclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_en_q <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            word_cnt <= '0;
            beat_cnt <= '0;
            to_cnt   <= '0;
            abort_q  <= 1'b0;
            lb_we    <= 1'b0;
            lb_waddr <= '0;
            lb_wdata <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            lb_we <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (len_words != '0) begin
                            len_q    <= len_words;
                            word_cnt <= '0;
                            addr_q   <= {base_addr[22:2], 2'b00};
                            abort_q  <= 1'b0;
                            cmd_en_q <= 1'b1;
                            busy     <= 1'b1;
                            state    <= REQ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // A grant wins over abort: the burst is then drained.
                    if (bus.cmd_ready) begin
                        cmd_en_q <= 1'b0;
                        beat_cnt <= '0;
                        to_cnt   <= '0;
                        abort_q  <= abort;
                        state    <= DATA;
                    end else if (abort) begin
                        cmd_en_q <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DATA: begin
                    // Expiry takes priority over a coincident beat.
                    if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (abort) begin
                            abort_q <= 1'b1;
                        end
                        if (bus.rvalid) begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (word_cnt < len_q && !(abort || abort_q)) begin
                                lb_we    <= 1'b1;
                                lb_waddr <= word_cnt;
                                lb_wdata <= bus.rdata;
                                word_cnt <= word_cnt + 1'b1;
                            end
                            if (beat_cnt == BCW'(BURST_WORDS - 1)) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (word_cnt >= len_q || abort || abort_q) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        addr_q   <= addr_q + 23'(BURST_WORDS * 4);
                        cmd_en_q <= 1'b1;
                        state    <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_line_fetch.sv
// Scoreboard bench for psram_line_fetch with a behavioural arbiter.
// Expected requests and writes are queued at launch; a monitor pops them.
module tb_psram_line_fetch;
    localparam int BW = 8;
    localparam int LW = 11;
    localparam int TO = 255;
    localparam int NOSTOP = 32'h7fffffff;

    logic          psramclk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [22:0]   base_addr;
    logic [LW-1:0] len_words;
    logic          lb_we;
    logic [LW-1:0] lb_waddr;
    logic [31:0]   lb_wdata;
    logic          busy;
    logic          done;
    logic          err;

    psram_line_fetch_if bus();

    psram_line_fetch #(
        .BURST_WORDS(BW),
        .LEN_W(LW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .psramclk(psramclk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .len_words(len_words),
        .bus(bus),
        .lb_we(lb_we),
        .lb_waddr(lb_waddr),
        .lb_wdata(lb_wdata),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 psramclk = ~psramclk;

    int errs;
    int chks;
    logic [63:0] exp_wr[$];
    logic [22:0] exp_addr[$];
    logic [31:0] data_arr[0:4095];
    int beat_no;
    int grant_delay;
    int stop_beat;
    int abort_beat;
    int done_cnt;
    int done_base;
    int done_cyc;
    int grant_cyc;
    int cyc;
    int fetch_k0;
    int ast;
    int acnt;
    int anb;
    int agap;
    logic pcen;
    logic pdone;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic fail(input string n);
        chks++;
        errs++;
        $display("FAIL %s: got unexpected event expected none", n);
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_en", 64'(bus.cmd_en), 0);
        chk("rst_addr", 64'(bus.addr), 0);
        chk("rst_lb_we", 64'(lb_we), 0);
        chk("rst_lb_waddr", 64'(lb_waddr), 0);
        chk("rst_lb_wdata", 64'(lb_wdata), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
    endtask

    // Reference: bursts = ceil(len/BW); writes for words below len and
    // before abort/stall; one request per burst actually started.
    task automatic launch(input logic [22:0] b, input int len, input int gd,
                          input int ab_rel, input int st_rel);
        int nb;
        int nreq;
        int nwr;
        logic [22:0] a0;
        nb   = (len + BW - 1) / BW;
        nreq = nb;
        nwr  = len;
        if (ab_rel > 0) begin
            nreq = (ab_rel + BW - 1) / BW;
            nwr  = (ab_rel - 1 < len) ? ab_rel - 1 : len;
        end
        if (st_rel > 0) begin
            nreq = st_rel / BW + 1;
            if (nreq > nb) nreq = nb;
            nwr = (st_rel < len) ? st_rel : len;
        end
        a0 = {b[22:2], 2'b00};
        fetch_k0 = beat_no;
        for (int i = 0; i < nb * BW; i++)
            data_arr[(fetch_k0 + i) % 4096] = $urandom;
        for (int i = 0; i < nreq; i++)
            exp_addr.push_back(a0 + 23'(i * BW * 4));
        for (int i = 0; i < nwr; i++)
            exp_wr.push_back({32'(i), data_arr[(fetch_k0 + i) % 4096]});
        grant_delay = gd;
        abort_beat  = (ab_rel > 0) ? fetch_k0 + ab_rel : 0;
        stop_beat   = (st_rel > 0) ? fetch_k0 + st_rel : NOSTOP;
        done_base   = done_cnt;
        @(negedge psramclk);
        start     = 1'b1;
        base_addr = b;
        len_words = LW'(len);
        @(negedge psramclk);
        start = 1'b0;
    endtask

    task automatic finish_fetch(input logic exp_err);
        int i;
        i = 0;
        while (done_cnt == done_base && i < 4000) begin
            @(posedge psramclk);
            i++;
        end
        if (done_cnt == done_base) fail("done_wait_timeout");
        repeat (3) @(negedge psramclk);
        chk("done_count", 64'(done_cnt - done_base), 1);
        chk("err", 64'(err), 64'(exp_err));
        chk("busy_end", 64'(busy), 0);
        chk("req_left", 64'(exp_addr.size()), 0);
        chk("wr_left", 64'(exp_wr.size()), 0);
        abort_beat = 0;
        stop_beat  = NOSTOP;
        repeat (2) @(negedge psramclk);
    endtask

    initial begin
        logic got;
        int n;
        errs = 0; chks = 0; beat_no = 0; done_cnt = 0; done_base = 0;
        done_cyc = 0; grant_cyc = 0; cyc = 0; grant_delay = 0;
        stop_beat = NOSTOP; abort_beat = 0; ast = 0; acnt = 0; anb = 0;
        agap = 0; pcen = 1'b0; pdone = 1'b0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; len_words = '0;
        bus.cmd_ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;

        fork
            forever begin
                @(posedge psramclk);
                cyc++;
            end
            forever begin
                @(negedge psramclk);
                bus.cmd_ready = 1'b0;
                bus.rvalid    = 1'b0;
                if (abort_beat == 0) abort = 1'b0;
                case (ast)
                    0: if (rst_n && bus.cmd_en) begin
                        acnt = grant_delay;
                        ast  = 1;
                    end
                    1: if (!bus.cmd_en) begin
                        ast = 0;
                    end else if (acnt == 0) begin
                        bus.cmd_ready = 1'b1;
                        grant_cyc = cyc + 1;
                        anb  = 0;
                        agap = $urandom_range(0, 2);
                        ast  = 2;
                    end else begin
                        acnt--;
                    end
                    default: if (agap > 0) begin
                        agap--;
                    end else if (beat_no >= stop_beat) begin
                        ast = 0;
                    end else begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = data_arr[beat_no % 4096];
                        beat_no++;
                        anb++;
                        if (abort_beat != 0 && beat_no == abort_beat) abort = 1'b1;
                        agap = $urandom_range(0, 2);
                        if (anb == BW) ast = 0;
                    end
                endcase
            end
            forever begin
                @(negedge psramclk);
                if (rst_n) begin
                    if (bus.cmd_en && !pcen) begin
                        if (exp_addr.size() == 0) fail("req_extra");
                        else chk("req_addr", 64'(bus.addr), 64'(exp_addr.pop_front()));
                    end
                    if (lb_we) begin
                        if (exp_wr.size() == 0) fail("wr_extra");
                        else chk("lb_write", {32'(lb_waddr), lb_wdata}, exp_wr.pop_front());
                    end
                    if (done) begin
                        chk("done_width", 64'(pdone), 0);
                        done_cnt++;
                        done_cyc = cyc;
                    end
                end
                pcen  = bus.cmd_en;
                pdone = done;
            end
        join_none

        repeat (3) @(negedge psramclk);
        check_reset_vals();
        chk("const_cmd", 64'(bus.cmd), 0);
        chk("const_wdata", 64'(bus.wdata), 0);
        chk("const_mask", 64'(bus.mask), 64'hF);
        rst_n = 1'b1;
        repeat (2) @(negedge psramclk);

        launch(23'h000100, 16, 3, 0, 0);
        finish_fetch(1'b0);

        launch(23'h000200, 10, 2, 0, 0);
        finish_fetch(1'b0);

        launch(23'h002000, 8, 40, 0, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge psramclk);
            chk("hold", {bus.cmd_en, busy, lb_we, done, err, bus.addr},
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 23'h002000});
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge psramclk);
            if (bus.cmd_ready) got = 1'b1;
        end
        #1;
        chk("grant_seen", 64'(got), 1);
        chk("cmd_en_fall", 64'(bus.cmd_en), 0);
        finish_fetch(1'b0);

        launch(23'h003000, 32, 2, 3, 0);
        finish_fetch(1'b0);

        launch(23'h000300, 16, 2, 0, 5);
        finish_fetch(1'b1);
        chk("to_latency", 64'(done_cyc - grant_cyc), 64'(TO));
        launch(23'h000400, 8, 1, 0, 0);
        chk("err_clear", 64'(err), 0);
        finish_fetch(1'b0);

        launch(23'h7FFFF0, 16, 2, 0, 0);
        finish_fetch(1'b0);

        launch(23'h000500, 32, 3, 0, 0);
        repeat (10) @(negedge psramclk);
        chk("busy_mid", 64'(busy), 1);
        start = 1'b1; base_addr = 23'h007000; len_words = LW'(3);
        @(negedge psramclk);
        start = 1'b0;
        finish_fetch(1'b0);

        done_base = done_cnt;
        @(negedge psramclk);
        start = 1'b1; len_words = '0;
        @(posedge psramclk);
        #1;
        chk("len0_done", 64'(done), 1);
        chk("len0_busy", 64'(busy), 0);
        @(negedge psramclk);
        start = 1'b0;
        @(posedge psramclk);
        #1;
        chk("len0_done_off", 64'(done), 0);
        repeat (3) @(negedge psramclk);
        chk("len0_count", 64'(done_cnt - done_base), 1);

        for (int k = 0; k < 6; k++) begin
            launch(23'($urandom), $urandom_range(1, 40), $urandom_range(0, 5), 0, 0);
            finish_fetch(1'b0);
        end

        launch(23'h001000, 16, 2, 0, 0);
        n = 0;
        while (beat_no < fetch_k0 + 3 && n < 500) begin
            @(negedge psramclk);
            n++;
        end
        chk("rst_mid_reached", 64'(beat_no >= fetch_k0 + 3), 1);
        @(negedge psramclk);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        exp_addr.delete();
        exp_wr.delete();
        repeat (2) @(negedge psramclk);
        rst_n = 1'b1;
        repeat (30) @(negedge psramclk);
        chk("post_rst_busy", 64'(busy), 0);

        launch(23'h000600, 12, 1, 0, 0);
        finish_fetch(1'b0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule

// File: doc/psram_line_fetch.md
# psram_line_fetch

Read-only burst fetch controller for one requester port of the 3-channel PSRAM arbiter. On a start pulse it issues consecutive PSRAM read bursts from a base address, steers the returned words into a line-buffer write port, and reports completion. It sits between the display/photo line pipeline and arbiter channel s1 or s2. At most one burst is outstanding at any time.

## Interface
- BURST_WORDS, 8: 32-bit words returned per PSRAM read command. Must be a power of 2, ≤ 16.
- LEN_W, 11: width of the line length and line-buffer address.
- TIMEOUT_CYC, 255: maximum number of cycles from command acceptance to the final beat of a burst.
- psramclk, in, 1: the single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse that launches a line fetch. Ignored while busy=1.
- abort, in, 1: level. Stops the fetch at the next safe point.
- base_addr, in, 23: PSRAM byte address of the first word. Sampled on start. Bits [1:0] are ignored.
- len_words, in, LEN_W: number of words to deliver. Sampled on start. 0 means no fetch.
- cmd, out, 1: arbiter command. Constant 0 (read).
- cmd_en, out, 1: arbiter request.
- addr, out, 23: arbiter address.
- wdata, out, 32: constant 0.
- mask, out, 4: constant 4'hF.
- cmd_ready, in, 1: arbiter one-cycle grant.
- rdata, in, 32: arbiter read data.
- rvalid, in, 1: arbiter read-data strobe.
- lb_we, out, 1: line-buffer write enable.
- lb_waddr, out, LEN_W: line-buffer word address.
- lb_wdata, out, 32: line-buffer write data.
- busy, out, 1: a fetch is in progress.
- done, out, 1: one-cycle pulse at the end of a fetch.
- err, out, 1: sticky timeout flag. Cleared by the next accepted start.

## Operation
- States: IDLE, REQ, DATA, CHECK.
- IDLE:
  - start with len_words≠0: latch base_addr and len_words, clear word_cnt, clear err, go to REQ.
  - start with len_words=0: pulse done the next cycle and stay in IDLE.
- REQ:
  - cmd_en=1 and addr=current burst address.
  - Grant is the condition cmd_en&cmd_ready at a clock edge. On grant: cmd_en=0 from the next cycle, clear beat_cnt and the timeout counter, go to DATA.
  - The arbiter never re-grants a dropped request. The block does not deassert cmd_en before grant, except when abort is high.
- DATA:
  - Each rvalid increments beat_cnt.
  - If word_cnt<len, the beat is written: lb_we=1, lb_waddr=word_cnt, lb_wdata=rdata, then word_cnt+1.
  - Beats with word_cnt≥len are discarded. These are the tail beats of a partial last burst.
  - When beat_cnt reaches BURST_WORDS, go to CHECK.
- CHECK:
  - word_cnt≥len or abort: pulse done and go to IDLE.
  - Otherwise advance addr by BURST_WORDS*4 and go to REQ.
- Address arithmetic is 23-bit and wraps modulo 2^23 with no flag.
- abort behaviour by state:
  - In REQ before grant: drop cmd_en, pulse done, go to IDLE.
  - In DATA: finish draining the outstanding burst with lb_we suppressed, then go to IDLE and pulse done.
- Timeout: if TIMEOUT_CYC cycles pass in DATA without the burst completing, set err=1, pulse done, go to IDLE.
- busy=1 in REQ, DATA and CHECK. busy=0 in IDLE.

## Timing
- Reset values: cmd_en=0, addr=0, lb_we=0, lb_waddr=0, lb_wdata=0, busy=0, done=0, err=0, state=IDLE. cmd=0, wdata=0 and mask=4'hF always.
- Reset assertion mid-fetch returns the block to IDLE immediately. Beats that arrive later are ignored because the state is IDLE.
- start to cmd_en=1: 1 cycle.
- cmd_ready high at edge N: cmd_en=0 from N+1.
- All outputs are registered.
- rvalid at edge N: lb_we, lb_waddr and lb_wdata are valid for one cycle after edge N, i.e. 1-cycle latency.
- Last beat of a burst to the next cmd_en=1: 2 cycles (DATA→CHECK→REQ).
- done is asserted one cycle after CHECK exits, and for exactly 1 cycle.
- Simultaneous events:
  - start and abort together in IDLE: start wins.
  - abort during the grant cycle: the grant is already taken, so the block drains the burst.
  - rvalid in the same cycle as the timeout expiry: timeout wins.

## Test plan
- len_words=16, base=0x000100, BURST_WORDS=8, arbiter grants after 3 cycles:
  - Exactly 2 requests, at addr 0x000100 and 0x000120.
  - 16 lb_we pulses with lb_waddr 0..15 and data matching.
  - One done pulse; err=0.
- len_words=10:
  - 2 bursts issued.
  - 10 writes; beats 11–16 produce no lb_we.
  - done is asserted after the 16th beat.
- cmd_ready withheld for 40 cycles:
  - cmd_en stays high the whole time and no other output changes.
  - On grant, cmd_en falls the following cycle.
- abort asserted during the 3rd beat of burst 1 with len=32:
  - No lb_we after abort.
  - The block waits for 8 beats, pulses done, and issues no second request.
- rvalid stops after 5 beats:
  - err=1 and done pulse TIMEOUT_CYC cycles after grant; busy=0.
  - The next start clears err.
- base=0x7FFFF0, len=16:
  - Second request address is 0x000010 (wrap).
- start pulsed while busy: no effect.
- Reset mid-DATA: all outputs return to their reset values.
